multicycle_ctrl: RTL and testbench

Moore control FSM for the multicycle RV32 core: sequences fetch, decode, execute, memory and writeback over several cycles, stalls on a memory ready handshake, and halts on illegal opcodes or memory timeouts. Sits between the instruction register (`op`), the ALU (`zero`) and the unified instruction/data memory (`memReady`). It drives every datapath mux and enable, and optionally counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle controller and its datapath/memory.
//   Datapath -> controller : op (opcode), zero (ALU flag), memReady (memory done)
//   Controller -> datapath : pcWrite, adrSrc, memWrite, irWrite, resultSrc,
//                            aluSrcA, aluSrcB, aluOp, immSrc, regWrite
//   Status                 : halted, illegal, busErr, instret
// Modports:
//   master : datapath side (drives op/zero/memReady, receives controls)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             zero;
   logic             memReady;
   logic             pcWrite;
   logic             adrSrc;
   logic             memWrite;
   logic             irWrite;
   logic [1:0]       resultSrc;
   logic [1:0]       aluSrcA;
   logic [1:0]       aluSrcB;
   logic [1:0]       aluOp;
   logic [1:0]       immSrc;
   logic             regWrite;
   logic             halted;
   logic             illegal;
   logic             busErr;
   logic [CNT_W-1:0] instret;

   modport master (
      output op, zero, memReady,
      input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
             aluOp, immSrc, regWrite, halted, illegal, busErr, instret
   );

   modport slave (
      input  op, zero, memReady,
      output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
             aluOp, immSrc, regWrite, halted, illegal, busErr, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for the multicycle RV32 core. Sequences fetch, decode,
// execute, memory and writeback; stalls on memReady; halts on an illegal
// opcode or on a memory wait timeout.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; forces every control output to 0
//   bus   : multicycle_ctrl_if.slave (opcode/flags in, controls/status out)
// Parameters:
//   CNT_W      : width of the retired-instruction counter
//   WAIT_LIMIT : memory-wait cycles tolerated before a bus error (1..255)
// Configuration macro:
//   MCCTRL_INSTRET_EN : when defined, instret counts retired instructions;
//                       otherwise instret is tied to 0.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_W      = 32,
   parameter int WAIT_LIMIT = 15
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.slave   bus
);

   localparam logic [6:0] OP_LW   = 7'd3;
   localparam logic [6:0] OP_ITYP = 7'd19;
   localparam logic [6:0] OP_SW   = 7'd35;
   localparam logic [6:0] OP_RTYP = 7'd51;
   localparam logic [6:0] OP_BEQ  = 7'd99;
   localparam logic [6:0] OP_JAL  = 7'd111;
   localparam logic [7:0] WAIT_LIM_8 = 8'(WAIT_LIMIT);

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
      ST_EXECUTER, ST_EXECUTEI, ST_ALUWB, ST_BEQ, ST_JAL, ST_HALT
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_wait;
   logic       r_illegal;
   logic       r_busErr;

   logic       w_mem_state;
   logic       w_timeout;
   logic       w_set_illegal;
   logic       w_set_buserr;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_adr_src;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_halted;
   logic [1:0] w_result_src;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_imm_src;

   // States that wait on the memory handshake
   assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMREAD) ||
                        (r_state == ST_MEMWRITE);
   // Counter has already absorbed WAIT_LIMIT stalled cycles and memory is
   // still not ready: give up on this access
   assign w_timeout   = w_mem_state && !bus.memReady && (r_wait == WAIT_LIM_8);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_FETCH;
         r_wait    <= 8'd0;
         r_illegal <= 1'b0;
         r_busErr  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Only a stalled memory state keeps its state; every transition
         // (including re-entry of FETCH) starts the count from zero
         if (w_mem_state && (w_state_next == r_state)) begin
            r_wait <= r_wait + 8'd1;
         end else begin
            r_wait <= 8'd0;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
         if (w_set_buserr) begin
            r_busErr <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_set_illegal = 1'b0;
      w_set_buserr  = 1'b0;
      w_pc_update   = 1'b0;
      w_branch      = 1'b0;
      w_adr_src     = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_write   = 1'b0;
      w_halted      = 1'b0;
      w_result_src  = 2'b00;
      w_alu_src_a   = 2'b00;
      w_alu_src_b   = 2'b00;
      w_alu_op      = 2'b00;
      case (r_state)
         ST_FETCH: begin
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            if (bus.memReady) begin
               w_ir_write   = 1'b1;
               w_pc_update  = 1'b1;
               w_state_next = ST_DECODE;
            end else if (w_timeout) begin
               w_set_buserr = 1'b1;
               w_state_next = ST_HALT;
            end
         end
         ST_DECODE: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: w_state_next = ST_MEMADR;
               OP_RTYP:      w_state_next = ST_EXECUTER;
               OP_ITYP:      w_state_next = ST_EXECUTEI;
               OP_BEQ:       w_state_next = ST_BEQ;
               OP_JAL:       w_state_next = ST_JAL;
               default: begin
                  w_set_illegal = 1'b1;
                  w_state_next  = ST_HALT;
               end
            endcase
         end
         ST_MEMADR: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_state_next = (bus.op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
         end
         ST_MEMREAD: begin
            w_adr_src = 1'b1;
            if (bus.memReady) begin
               w_state_next = ST_MEMWB;
            end else if (w_timeout) begin
               w_set_buserr = 1'b1;
               w_state_next = ST_HALT;
            end
         end
         ST_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_state_next = ST_FETCH;
         end
         ST_MEMWRITE: begin
            // Strobe held for the whole stall so the memory sees a stable write
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            if (bus.memReady) begin
               w_state_next = ST_FETCH;
            end else if (w_timeout) begin
               w_set_buserr = 1'b1;
               w_state_next = ST_HALT;
            end
         end
         ST_EXECUTER: begin
            w_alu_src_a  = 2'b10;
            w_alu_op     = 2'b10;
            w_state_next = ST_ALUWB;
         end
         ST_EXECUTEI: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_alu_op     = 2'b10;
            w_state_next = ST_ALUWB;
         end
         ST_ALUWB: begin
            w_reg_write  = 1'b1;
            w_state_next = ST_FETCH;
         end
         ST_BEQ: begin
            w_alu_src_a  = 2'b10;
            w_alu_op     = 2'b01;
            w_branch     = 1'b1;
            w_state_next = ST_FETCH;
         end
         ST_JAL: begin
            w_alu_src_a  = 2'b01;
            w_alu_src_b  = 2'b10;
            w_pc_update  = 1'b1;
            w_state_next = ST_ALUWB;
         end
         ST_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_state_next = ST_HALT;
         end
      endcase
   end

   always_comb begin
      w_imm_src = 2'b00;
      case (bus.op)
         OP_SW:   w_imm_src = 2'b01;
         OP_BEQ:  w_imm_src = 2'b10;
         OP_JAL:  w_imm_src = 2'b11;
         default: w_imm_src = 2'b00;
      endcase
   end

   // Reset masks every control output combinationally so an in-flight
   // write strobe drops the moment reset rises
   assign bus.pcWrite   = !reset && (w_pc_update || (w_branch && bus.zero));
   assign bus.adrSrc    = !reset && w_adr_src;
   assign bus.memWrite  = !reset && w_mem_write;
   assign bus.irWrite   = !reset && w_ir_write;
   assign bus.regWrite  = !reset && w_reg_write;
   assign bus.halted    = !reset && w_halted;
   assign bus.resultSrc = reset ? 2'b00 : w_result_src;
   assign bus.aluSrcA   = reset ? 2'b00 : w_alu_src_a;
   assign bus.aluSrcB   = reset ? 2'b00 : w_alu_src_b;
   assign bus.aluOp     = reset ? 2'b00 : w_alu_op;
   assign bus.immSrc    = reset ? 2'b00 : w_imm_src;
   assign bus.illegal   = r_illegal;
   assign bus.busErr    = r_busErr;

`ifdef MCCTRL_INSTRET_EN
   logic [CNT_W-1:0] r_instret;
   logic             w_retire;

   // An instruction retires when its last state hands back to FETCH; HALT
   // never returns to FETCH, and a timed-out store did not complete
   assign w_retire = (w_state_next == ST_FETCH) &&
                     ((r_state == ST_MEMWB) || (r_state == ST_MEMWRITE) ||
                      (r_state == ST_ALUWB) || (r_state == ST_BEQ));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + 1'b1;
      end
   end

   assign bus.instret = r_instret;
`else
   assign bus.instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Table of per-cycle vectors (inputs plus the state the controller is
// expected to be in); expected outputs come from the per-state output table
// and are queued when a row is driven, then popped and compared mid-cycle.
// A hand-written sequence covers reset asserted during a stalled store.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
   localparam int CNT_W      = 4;
   localparam int WAIT_LIMIT = 15;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

   multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef enum int {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
      T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_HALT
   } tst_e;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic       zero;
      logic       rdy;
      tst_e       st;
      logic       ill;
      logic       berr;
   } vec_t;

   typedef struct {
      logic [15:0]      ctrl;
      logic [5:0]       status;   // {illegal, busErr, instret}
      int               idx;
   } exp_t;

   vec_t             vecs[$];
   exp_t             sb[$];
   int               checks   = 0;
   int               failures = 0;
   logic             g_ill    = 1'b0;
   logic             g_berr   = 1'b0;
   logic [CNT_W-1:0] model_cnt = '0;

   logic [15:0] act_ctrl;
   logic [5:0]  act_status;
   assign act_ctrl   = {bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite,
                        bus.resultSrc, bus.aluSrcA, bus.aluSrcB, bus.aluOp,
                        bus.immSrc, bus.regWrite, bus.halted};
   assign act_status = {bus.illegal, bus.busErr, bus.instret};

   function automatic logic [15:0] exp_ctrl(vec_t v);
      logic pcu, br, adr, mw, irw, rw, hl;
      logic [1:0] rs, sa, bsel, ao, im;
      {pcu, br, adr, mw, irw, rw, hl} = 7'b0;
      {rs, sa, bsel, ao, im} = 10'b0;
      if (v.rst) return 16'h0000;
      case (v.op)
         7'd35:   im = 2'b01;
         7'd99:   im = 2'b10;
         7'd111:  im = 2'b11;
         default: im = 2'b00;
      endcase
      case (v.st)
         T_FETCH:    begin irw = v.rdy; pcu = v.rdy; bsel = 2'b10; rs = 2'b10; end
         T_DECODE:   begin sa = 2'b01; bsel = 2'b01; end
         T_MEMADR:   begin sa = 2'b10; bsel = 2'b01; end
         T_MEMREAD:  begin adr = 1'b1; end
         T_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
         T_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
         T_EXECR:    begin sa = 2'b10; ao = 2'b10; end
         T_EXECI:    begin sa = 2'b10; bsel = 2'b01; ao = 2'b10; end
         T_ALUWB:    begin rw = 1'b1; end
         T_BEQ:      begin sa = 2'b10; ao = 2'b01; br = 1'b1; end
         T_JAL:      begin sa = 2'b01; bsel = 2'b10; pcu = 1'b1; end
         default:    begin hl = 1'b1; end
      endcase
      return {pcu | (br & v.zero), adr, mw, irw, rs, sa, bsel, ao, im, rw, hl};
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt(logic [CNT_W-1:0] m);
`ifdef MCCTRL_INSTRET_EN
      return m;
`else
      return (m & '0);
`endif
   endfunction

   task automatic add(input logic r, input logic [6:0] op, input logic z,
                      input logic rdy, input tst_e st);
      vec_t v;
      v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st;
      v.ill = r ? 1'b0 : g_ill;
      v.berr = r ? 1'b0 : g_berr;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      vec_t v;
      exp_t e;
      exp_t got;

      bus.op = 7'd0; bus.zero = 1'b0; bus.memReady = 1'b0;

      // ---------------- vector table ----------------
      add(1, 7'd3, 0, 1, T_FETCH);                       // reset held
      add(0, 7'd3, 0, 1, T_FETCH);   add(0, 7'd3, 0, 1, T_DECODE);   // lw
      add(0, 7'd3, 0, 1, T_MEMADR);  add(0, 7'd3, 0, 1, T_MEMREAD);
      add(0, 7'd3, 0, 1, T_MEMWB);
      add(0, 7'd35, 0, 1, T_FETCH);  add(0, 7'd35, 0, 0, T_DECODE);  // sw, 3 waits
      add(0, 7'd35, 0, 0, T_MEMADR);
      for (int k = 0; k < 3; k++) add(0, 7'd35, 0, 0, T_MEMWRITE);
      add(0, 7'd35, 0, 1, T_MEMWRITE);
      add(0, 7'd99, 1, 1, T_FETCH);  add(0, 7'd99, 1, 0, T_DECODE);  // beq taken
      add(0, 7'd99, 1, 0, T_BEQ);
      add(0, 7'd99, 0, 1, T_FETCH);  add(0, 7'd99, 0, 0, T_DECODE);  // beq not taken
      add(0, 7'd99, 0, 0, T_BEQ);
      add(0, 7'd111, 1, 1, T_FETCH); add(0, 7'd111, 1, 0, T_DECODE); // jal
      add(0, 7'd111, 1, 0, T_JAL);   add(0, 7'd111, 1, 0, T_ALUWB);
      add(0, 7'd19, 1, 1, T_FETCH);  add(0, 7'd19, 1, 1, T_DECODE);  // I-type
      add(0, 7'd19, 1, 1, T_EXECI);  add(0, 7'd19, 1, 1, T_ALUWB);
      for (int k = 0; k < WAIT_LIMIT; k++) add(0, 7'd51, 0, 0, T_FETCH); // max waits
      add(0, 7'd51, 0, 1, T_FETCH);  add(0, 7'd51, 0, 0, T_DECODE);
      add(0, 7'd51, 0, 0, T_EXECR);  add(0, 7'd51, 0, 0, T_ALUWB);
      for (int k = 0; k < 17; k++) begin                  // counter wrap
         add(0, 7'd51, 0, 1, T_FETCH); add(0, 7'd51, 0, 1, T_DECODE);
         add(0, 7'd51, 0, 1, T_EXECR); add(0, 7'd51, 0, 1, T_ALUWB);
      end
      add(0, 7'h7F, 0, 1, T_FETCH);  add(0, 7'h7F, 0, 1, T_DECODE);  // illegal
      g_ill = 1'b1;
      add(0, 7'd51, 1, 1, T_HALT);   add(0, 7'd51, 1, 0, T_HALT);
      add(0, 7'd3, 1, 1, T_HALT);
      add(1, 7'd3, 0, 1, T_FETCH);
      g_ill = 1'b0;
      for (int k = 0; k <= WAIT_LIMIT; k++) add(0, 7'd3, 0, 0, T_FETCH); // timeout
      g_berr = 1'b1;
      add(0, 7'd3, 0, 1, T_HALT);    add(0, 7'd3, 0, 0, T_HALT);
      add(1, 7'd35, 0, 1, T_FETCH);
      g_berr = 1'b0;
      add(0, 7'd35, 0, 1, T_FETCH);  add(0, 7'd35, 0, 1, T_DECODE);  // sw, no wait
      add(0, 7'd35, 0, 1, T_MEMADR); add(0, 7'd35, 0, 1, T_MEMWRITE);

      // ---------------- apply table ----------------
      @(posedge clk); #1;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         reset = v.rst; bus.op = v.op; bus.zero = v.zero; bus.memReady = v.rdy;
         if (v.rst) model_cnt = '0;
         e.ctrl   = exp_ctrl(v);
         e.status = {v.ill, v.berr, exp_cnt(model_cnt)};
         e.idx    = i;
         sb.push_back(e);
         @(negedge clk);
         got = sb.pop_front();
         check($sformatf("ctrl_%s", v.rst ? "RESET" : v.st.name()), got.idx,
               32'(act_ctrl), 32'(got.ctrl));
         check("status", got.idx, 32'(act_status), 32'(got.status));
         $display("row %0d rst=%0b op=%0d rdy=%0b st=%s ctrl=%h status=%h",
                  i, v.rst, v.op, v.rdy, v.st.name(), act_ctrl, act_status);
         if (!v.rst && ((v.st == T_MEMWB) || (v.st == T_ALUWB) || (v.st == T_BEQ) ||
                        ((v.st == T_MEMWRITE) && v.rdy)))
            model_cnt = model_cnt + 1'b1;
         @(posedge clk); #1;
      end

      // ---------------- reset during a stalled store ----------------
      bus.op = 7'd35; bus.zero = 1'b0; bus.memReady = 1'b1;   // FETCH
      @(posedge clk); #1;                                      // DECODE
      @(posedge clk); #1;                                      // MEMADR
      @(posedge clk); #1;                                      // MEMWRITE
      bus.memReady = 1'b0;
      #2;
      check("sw_stall_memWrite", 0, 32'(bus.memWrite), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_mid_ctrl", 0, 32'(act_ctrl), 32'd0);
      check("rst_mid_status", 0, 32'(act_status), 32'd0);
      $display("reset mid-store ctrl=%h status=%h", act_ctrl, act_status);
      @(posedge clk); #1;
      reset = 1'b0; bus.op = 7'd3; bus.memReady = 1'b1;
      v.rst = 0; v.op = 7'd3; v.zero = 0; v.rdy = 1; v.st = T_FETCH;
      #1;
      check("post_rst_fetch", 0, 32'(act_ctrl), 32'(exp_ctrl(v)));
      @(posedge clk); #1;
      v.st = T_DECODE;
      check("post_rst_decode", 0, 32'(act_ctrl), 32'(exp_ctrl(v)));
      check("post_rst_status", 0, 32'(act_status), 32'd0);
      $display("after reset release ctrl=%h status=%h", act_ctrl, act_status);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
